// File: rtl/fp_alu_issue_ctrl_if.sv
// Signal bundle between the FP ALU issue controller, its request/response client and the ALU.
// slave: the controller; master: the surrounding front end and ALU datapath.
interface fp_alu_issue_ctrl_if #(
  parameter int ADDR_W = 3
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_op_i;
  logic [31:0]       req_a_i;
  logic [31:0]       req_b_i;
  logic [31:0]       req_c_i;
  logic [2:0]        req_rmode_i;
  logic [3:0]        req_tag_i;

  logic [ADDR_W-1:0] alu_op_code_o;
  logic [31:0]       alu_fp_a_o;
  logic [31:0]       alu_fp_b_o;
  logic [31:0]       alu_fp_c_o;
  logic [2:0]        alu_r_mode_o;
  logic [31:0]       alu_fp_result_i;
  logic              alu_overflow_i;
  logic              alu_underflow_i;
  logic              alu_cmp_result_i;
  logic              alu_invalid_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_result_o;
  logic              rsp_cmp_o;
  logic [2:0]        rsp_flags_o;
  logic [3:0]        rsp_tag_o;

  logic [2:0]        sticky_flags_o;
  logic              flags_clr_i;
  logic              busy_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_c_i, req_rmode_i, req_tag_i,
    output req_ready_o,
    output alu_op_code_o, alu_fp_a_o, alu_fp_b_o, alu_fp_c_o, alu_r_mode_o,
    input  alu_fp_result_i, alu_overflow_i, alu_underflow_i, alu_cmp_result_i, alu_invalid_i,
    output rsp_valid_o, rsp_result_o, rsp_cmp_o, rsp_flags_o, rsp_tag_o,
    input  rsp_ready_i,
    output sticky_flags_o, busy_o,
    input  flags_clr_i
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_c_i, req_rmode_i, req_tag_i,
    input  req_ready_o,
    input  alu_op_code_o, alu_fp_a_o, alu_fp_b_o, alu_fp_c_o, alu_r_mode_o,
    output alu_fp_result_i, alu_overflow_i, alu_underflow_i, alu_cmp_result_i, alu_invalid_i,
    input  rsp_valid_o, rsp_result_o, rsp_cmp_o, rsp_flags_o, rsp_tag_o,
    output rsp_ready_i,
    input  sticky_flags_o, busy_o,
    output flags_clr_i
  );
endinterface

// File: rtl/fp_alu_issue_ctrl.sv
// FP ALU issue controller: queues requests, holds ALU inputs ALU_LAT cycles, returns tagged
// results; reserved op codes get a synthetic qNaN/invalid response. Sticky flags accumulate.
module fp_alu_issue_ctrl #(
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fp_alu_issue_ctrl_if.slave bus
);
  localparam int          PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [2:0]  LAST_CNT = 3'(ALU_LAT - 1);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] op;
    logic [31:0]       a;
    logic [31:0]       b;
    logic [31:0]       c;
    logic [2:0]        rmode;
    logic [3:0]        tag;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  req_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  state_t      r_state;
  state_t      w_state_nxt;
  req_t        r_issue;
  logic [2:0]  r_cnt;
  logic [31:0] r_rsp_result;
  logic        r_rsp_cmp;
  logic [2:0]  r_rsp_flags;
  logic [3:0]  r_rsp_tag;
  logic [2:0]  r_sticky;

  req_t       w_req;
  req_t       w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_head_rsvd;
  logic       w_cap_alu;
  logic       w_cap_rsvd;
  logic [2:0] w_cap_flags;
  logic       w_exec;

  assign w_req = {bus.req_op_i, bus.req_a_i, bus.req_b_i, bus.req_c_i,
                  bus.req_rmode_i, bus.req_tag_i};
  assign w_head      = r_mem[r_rptr];
  assign w_full      = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  // Ready depends only on occupancy, so a full FIFO never accepts even while popping.
  assign w_push      = bus.req_valid_i && !w_full;
  assign w_head_rsvd = (w_head.op >= ADDR_W'(5));

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_req;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_cap_alu   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = w_head_rsvd ? S_RESP : S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == LAST_CNT) begin
          w_cap_alu   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready_i) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = w_head_rsvd ? S_RESP : S_EXEC;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_cap_rsvd  = w_pop && w_head_rsvd;
  assign w_cap_flags = w_cap_alu  ? {bus.alu_invalid_i, bus.alu_overflow_i, bus.alu_underflow_i} :
                       w_cap_rsvd ? 3'b100 : 3'b000;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_issue      <= '0;
      r_cnt        <= '0;
      r_rsp_result <= '0;
      r_rsp_cmp    <= 1'b0;
      r_rsp_flags  <= '0;
      r_rsp_tag    <= '0;
      r_sticky     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      // Newly captured flags win over a simultaneous clear.
      r_sticky <= (bus.flags_clr_i ? 3'b000 : r_sticky) | w_cap_flags;
      if (w_pop) begin
        r_issue <= w_head;
        r_cnt   <= '0;
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_cap_alu) begin
        r_rsp_result <= bus.alu_fp_result_i;
        r_rsp_cmp    <= bus.alu_cmp_result_i;
        r_rsp_flags  <= w_cap_flags;
        r_rsp_tag    <= r_issue.tag;
      end else if (w_cap_rsvd) begin
        r_rsp_result <= QNAN;
        r_rsp_cmp    <= 1'b0;
        r_rsp_flags  <= w_cap_flags;
        r_rsp_tag    <= w_head.tag;
      end
    end
  end

  assign w_exec = (r_state == S_EXEC);

  assign bus.req_ready_o    = !w_full;
  assign bus.alu_op_code_o  = w_exec ? r_issue.op    : '0;
  assign bus.alu_fp_a_o     = w_exec ? r_issue.a     : '0;
  assign bus.alu_fp_b_o     = w_exec ? r_issue.b     : '0;
  assign bus.alu_fp_c_o     = w_exec ? r_issue.c     : '0;
  assign bus.alu_r_mode_o   = w_exec ? r_issue.rmode : '0;
  assign bus.rsp_valid_o    = (r_state == S_RESP);
  assign bus.rsp_result_o   = r_rsp_result;
  assign bus.rsp_cmp_o      = r_rsp_cmp;
  assign bus.rsp_flags_o    = r_rsp_flags;
  assign bus.rsp_tag_o      = r_rsp_tag;
  assign bus.sticky_flags_o = r_sticky;
  assign bus.busy_o         = !w_empty || (r_state != S_IDLE);
endmodule
